// File: rtl/count_mon_pkg.sv
// Shared types and helpers for the count rate monitor: FSM states,
// default widths and the saturating accumulate used by the datapath.
package count_mon_pkg;

    typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

    localparam int CW_DEF    = 5;
    localparam int RW_DEF    = 8;
    localparam int ACC_MAX_W = 16;

    // Returns {clipped, value}; value never exceeds 2^rw - 1.
    function automatic logic [ACC_MAX_W:0] sat_add(
        input logic [ACC_MAX_W-1:0] acc,
        input logic [ACC_MAX_W-1:0] inc,
        input int                   rw
    );
        logic [ACC_MAX_W:0] full;
        logic [ACC_MAX_W:0] lim;
        full = {1'b0, acc} + {1'b0, inc};
        lim  = ((ACC_MAX_W+1)'(1) << rw) - (ACC_MAX_W+1)'(1);
        if (full > lim) begin
            sat_add = {1'b1, lim[ACC_MAX_W-1:0]};
        end else begin
            sat_add = {1'b0, full[ACC_MAX_W-1:0]};
        end
    endfunction

endpackage

// File: rtl/count_rate_monitor_if.sv
// Bundle between the counter/consumer side and the rate monitor:
// sampled count and start in, rate result with flags out.
interface count_rate_monitor_if #(
    parameter int CW = 5,
    parameter int RW = 8
);
    logic [CW-1:0] count_in;
    logic          start;
    logic          out_ready;
    logic [RW-1:0] rate;
    logic          rate_valid;
    logic          over_flag;
    logic          under_flag;
    logic          sat_flag;
    logic          busy;

    modport master (
        output count_in, start, out_ready,
        input  rate, rate_valid, over_flag, under_flag, sat_flag, busy
    );

    modport slave (
        input  count_in, start, out_ready,
        output rate, rate_valid, over_flag, under_flag, sat_flag, busy
    );
endinterface

// File: rtl/sat_delta_accum.sv
// Wrap-safe delta of a free-running counter accumulated with saturation.
// sum/sat present the running total including the current sample's delta.
module sat_delta_accum
    import count_mon_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] sample,
    output logic [RW-1:0] sum,
    output logic          sat
);

    logic [CW-1:0]          prev;
    logic [RW-1:0]          sum_q;
    logic                   sat_q;
    logic [CW-1:0]          delta;
    logic [ACC_MAX_W:0]     add_res;
    logic                   clip;
    logic [ACC_MAX_W-1:RW]  res_hi_unused;

    // Modular subtraction in CW bits makes a 31->0 wrap read as +1.
    assign delta   = sample - prev;
    assign add_res = sat_add(ACC_MAX_W'(sum_q), ACC_MAX_W'(delta), RW);
    assign {clip, res_hi_unused, sum} = add_res;
    assign sat     = sat_q | clip;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev  <= '0;
            sum_q <= '0;
            sat_q <= 1'b0;
        end else if (clear) begin
            prev  <= sample;
            sum_q <= '0;
            sat_q <= 1'b0;
        end else if (enable) begin
            prev  <= sample;
            sum_q <= sum;
            sat_q <= sat;
        end
    end

endmodule

// File: rtl/count_rate_monitor.sv
// Measures counter increments over a fixed window and reports a saturated
// rate with threshold flags through a valid/ready handshake.
module count_rate_monitor
    import count_mon_pkg::*;
#(
    parameter int CW     = CW_DEF,
    parameter int RW     = RW_DEF,
    parameter int WINDOW = 16,
    parameter int HI_TH  = 20,
    parameter int LO_TH  = 2
) (
    input logic clk,
    input logic rst,
    count_rate_monitor_if.slave bus
);

    localparam int             WCW      = $clog2(WINDOW + 1);
    localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW - 1);

    state_t          state, state_next;
    logic [WCW-1:0]  win_cnt;
    logic            acc_clear;
    logic            acc_en;
    logic            load;
    logic [RW-1:0]   acc_sum;
    logic            acc_sat;
    logic [RW-1:0]   rate_q;
    logic            over_q;
    logic            under_q;
    logic            sat_q;

    sat_delta_accum #(
        .CW(CW),
        .RW(RW)
    ) u_accum (
        .clk    (clk),
        .rst    (rst),
        .clear  (acc_clear),
        .enable (acc_en),
        .sample (bus.count_in),
        .sum    (acc_sum),
        .sat    (acc_sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_clear  = 1'b0;
        acc_en     = 1'b0;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_clear  = 1'b1;
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                acc_en = 1'b1;
                if (win_cnt == WIN_LAST) begin
                    load       = 1'b1;
                    state_next = REPORT;
                end
            end
            REPORT: begin
                // Ready together with start re-arms without passing through IDLE.
                if (bus.out_ready) begin
                    if (bus.start) begin
                        acc_clear  = 1'b1;
                        state_next = MEASURE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt <= '0;
        end else if (acc_clear) begin
            win_cnt <= '0;
        end else if (acc_en) begin
            win_cnt <= win_cnt + WCW'(1);
        end
    end

    // Result registers hold their value after the handshake until the next load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rate_q  <= '0;
            over_q  <= 1'b0;
            under_q <= 1'b0;
            sat_q   <= 1'b0;
        end else if (load) begin
            rate_q  <= acc_sum;
            over_q  <= acc_sum > RW'(HI_TH);
            under_q <= acc_sum < RW'(LO_TH);
            sat_q   <= acc_sat;
        end
    end

    assign bus.rate       = rate_q;
    assign bus.rate_valid = (state == REPORT);
    assign bus.busy       = (state != IDLE);
    assign bus.over_flag  = over_q;
    assign bus.under_flag = under_q;
    assign bus.sat_flag   = sat_q;

endmodule

// File: tb/tb_count_rate_monitor.sv
// Randomized and directed bench for count_rate_monitor, checked every cycle
// against a window-level reference model plus hand-computed results.
module tb_count_rate_monitor;

    localparam int WIN = 16;
    localparam int HI  = 20;
    localparam int LO  = 2;

    typedef struct packed {
        int         phase;   // 0 waiting, 1 collecting samples, 2 holding result
        int         left;
        int         total;
        int         prev;
        logic [7:0] rate;
        logic       valid;
        logic       over;
        logic       under;
        logic       sat;
    } model_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    model_t m   = '0;
    bit     chk_on = 1'b0;
    int     checks = 0;
    int     failures = 0;

    count_rate_monitor_if #(.CW(5), .RW(8)) bus ();

    count_rate_monitor #(
        .CW(5), .RW(8), .WINDOW(WIN), .HI_TH(HI), .LO_TH(LO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Rate is the plain sum of modular increments over the window, clipped once at the end.
    function automatic model_t step(model_t s, logic st, logic rdy, logic [4:0] c);
        model_t n;
        n = s;
        case (s.phase)
            0: begin
                if (st) begin
                    n.phase = 1; n.prev = int'(c); n.total = 0; n.left = WIN;
                end
            end
            1: begin
                n.total = s.total + ((int'(c) - s.prev + 32) % 32);
                n.prev  = int'(c);
                n.left  = s.left - 1;
                if (n.left == 0) begin
                    n.phase = 2;
                    n.valid = 1'b1;
                    n.sat   = (n.total > 255);
                    n.rate  = n.sat ? 8'd255 : 8'(n.total);
                    n.over  = (int'(n.rate) > HI);
                    n.under = (int'(n.rate) < LO);
                end
            end
            default: begin
                if (rdy) begin
                    n.valid = 1'b0;
                    if (st) begin
                        n.phase = 1; n.prev = int'(c); n.total = 0; n.left = WIN;
                    end else begin
                        n.phase = 0;
                    end
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '0;
        else      m <= step(m, bus.start, bus.out_ready, bus.count_in);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("rate",       int'(bus.rate),       int'(m.rate));
            chk("rate_valid", int'(bus.rate_valid), int'(m.valid));
            chk("over_flag",  int'(bus.over_flag),  int'(m.over));
            chk("under_flag", int'(bus.under_flag), int'(m.under));
            chk("sat_flag",   int'(bus.sat_flag),   int'(m.sat));
            chk("busy",       int'(bus.busy),       (m.phase != 0) ? 1 : 0);
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_rate"},  int'(bus.rate), 0);
        chk({tag, "_valid"}, int'(bus.rate_valid), 0);
        chk({tag, "_over"},  int'(bus.over_flag), 0);
        chk({tag, "_under"}, int'(bus.under_flag), 0);
        chk({tag, "_sat"},   int'(bus.sat_flag), 0);
        chk({tag, "_busy"},  int'(bus.busy), 0);
    endtask

    // Caller has already driven start=1 with count_in=base for the accepting edge.
    task automatic feed(input int base, input int step_v);
        for (int i = 1; i <= WIN; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("armed_busy",  int'(bus.busy), 1);
                chk("armed_valid", int'(bus.rate_valid), 0);
            end
            if (i == WIN) chk("early_valid", int'(bus.rate_valid), 0);
            bus.start     = (i == 3 || i == 9);
            bus.out_ready = 1'b0;
            bus.count_in  = 5'(base + i * step_v);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int r, input int ov, input int un, input int st);
        chk({tag, "_valid"},     int'(bus.rate_valid), 1);
        chk({tag, "_rate"},      int'(bus.rate), r);
        chk({tag, "_over"},      int'(bus.over_flag), ov);
        chk({tag, "_under"},     int'(bus.under_flag), un);
        chk({tag, "_sat"},       int'(bus.sat_flag), st);
        chk({tag, "_model_rate"}, int'(m.rate), r);
    endtask

    task automatic ack(input int held_rate);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("ack_valid", int'(bus.rate_valid), 0);
        chk("ack_busy",  int'(bus.busy), 0);
        chk("ack_hold",  int'(bus.rate), held_rate);
    endtask

    task automatic start_at(input int base);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.count_in = 5'(base);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.count_in  = 5'($urandom);
        bus.start     = 1'($urandom);
        bus.out_ready = 1'($urandom);
        #1 rst = 1'b0;
        chk_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_zero("reset");
            bus.count_in  = 5'($urandom);
            bus.start     = 1'($urandom);
            bus.out_ready = 1'($urandom);
        end
        bus.start = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_zero("idle");

        start_at(10); feed(10, 1);  expect_result("inc",   16, 0, 0, 0); ack(16);
        start_at(28); feed(28, 1);  expect_result("wrap",  16, 0, 0, 0); ack(16);
        start_at(7);  feed(7, 0);   expect_result("const",  0, 0, 1, 0); ack(0);
        start_at(3);  feed(3, -1);  expect_result("dec",  255, 1, 1 == 0 ? 1 : 0, 1); ack(255);

        start_at(0); feed(0, 1); expect_result("hold", 16, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", int'(bus.rate_valid), 1);
            chk("hold_rate",  int'(bus.rate), 16);
        end
        bus.out_ready = 1'b1; bus.start = 1'b1; bus.count_in = 5'd4;
        feed(4, 2); expect_result("rearm", 32, 1, 0, 0); ack(32);

        start_at(0);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            bus.start    = 1'b0;
            bus.count_in = 5'(i);
        end
        #2 rst = 1'b0;
        #1 chk_zero("midreset");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_zero("inreset");
            bus.count_in  = 5'($urandom);
            bus.start     = 1'($urandom);
            bus.out_ready = 1'($urandom);
        end
        bus.start = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        start_at(9); feed(9, 1); expect_result("recover", 16, 0, 0, 0); ack(16);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 1) == 0) bus.count_in = bus.count_in + 5'($urandom_range(0, 3));
            else                           bus.count_in = 5'($urandom);
            bus.start     = ($urandom_range(0, 3) == 0);
            bus.out_ready = ($urandom_range(0, 1) == 0);
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        repeat (WIN + 4) @(negedge clk);
        chk("drain_busy", int'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_rate_monitor.md
# count_rate_monitor

Downstream consumer of the 5-bit free-running event counter. It samples the counter value over a programmable window of clock cycles and accumulates the modular (wrap-safe) increments. It then reports an 8-bit saturated event rate with over/under-threshold flags through a valid/ready output handshake. It sits between the event counter and the status/alarm logic.

## Interface
- `CW`, 5, width of sampled count input
- `RW`, 8, width of rate result (saturating)
- `WINDOW`, 16, measurement length in clock cycles (≥1)
- `HI_TH`, 20, over-threshold; `over_flag` when rate > HI_TH
- `LO_TH`, 2, under-threshold; `under_flag` when rate < LO_TH
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `count_in`  in  CW  sampled event count (free-running, wraps 31→0)
- `start`  in  1  request a measurement
- `out_ready`  in  1  consumer accepts result
- `rate`  out  RW  accumulated increments over last window
- `rate_valid`  out  1  result available
- `over_flag`, `under_flag`, `sat_flag`  out  1 each  result qualifiers (sat = accumulator clipped)
- `busy`  out  1  high in MEASURE or REPORT

## Operation
- States: IDLE, MEASURE, REPORT.
- IDLE: `start`=1 → `prev`←`count_in`, `sum`←0, `win_cnt`←0, go to MEASURE. Otherwise stay.
- MEASURE, every cycle:
  - delta = (`count_in` − `prev`) mod 2^CW, always in 0..31, never negative.
  - `sum` ← min(`sum`+delta, 2^RW−1); set internal sat bit if clipped.
  - `prev`←`count_in`, `win_cnt`++.
- MEASURE exit: when `win_cnt`==WINDOW−1, go to REPORT and register `rate`=final sum, with `over_flag`, `under_flag`, `sat_flag`.
- REPORT: `rate_valid`=1.
  - On `out_ready`=1: if `start`=1 in the same cycle, re-arm directly into MEASURE (capture baseline). Else go to IDLE.
- `start` outside IDLE/REPORT-handshake cycle: ignored, not queued.
- After handshake, `rate` and flags hold their last values until the next REPORT. Only `rate_valid` drops.
- Reset (any state, asynchronous): state IDLE, all outputs 0, `sum`/`prev`/`win_cnt` 0.

## Timing
- Start accepted at edge N. MEASURE samples at edges N+1..N+WINDOW. `rate_valid` is high from edge N+WINDOW.
- Latency start→valid = WINDOW cycles.
- Deltas cover samples N..N+WINDOW. The baseline is the sample at the start edge.
- `rate_valid` stays high and `rate`/flags stay stable while `out_ready`=0.
- On the handshake edge (`rate_valid`&&`out_ready`), `rate_valid` falls on that edge. Re-arm case: `busy` stays high.
- Outputs are registered; no combinational path from inputs to outputs.
- Boundaries:
  - Counter wrap 31→0 gives delta 1.
  - Unchanged count gives delta 0.
  - Saturation is sticky for the window.
  - WINDOW=1: one MEASURE cycle.

## Structure
- Package `count_mon_pkg`: state enum {IDLE, MEASURE, REPORT}, default CW/RW constants, and the saturating-add function.
- One sub-module `sat_delta_accum`:
  - Computes the mod-2^CW delta and the saturating accumulate.
  - Has clear/enable inputs and outputs sum + sat.
- FSM, window counter and result registers stay in the top level.

## Test plan
- Reset: drive `rst`=0 with random inputs → all outputs 0, `busy`=0. Release → IDLE.
- `count_in` +1 per cycle, start once (WINDOW=16) → after 16 cycles `rate`=16, `rate_valid`=1, all flags 0.
- Baseline 28, +1 per cycle through 31→0 → `rate`=16 (wrap-safe). Constant `count_in` → `rate`=0, `under_flag`=1.
- `count_in` −1 per cycle (delta 31) for 16 cycles → 496 clipped: `rate`=255, `sat_flag`=1, `over_flag`=1.
- Hold `out_ready`=0 for 5 cycles in REPORT → `rate_valid`, `rate` stable. Ready+start together → new MEASURE with no IDLE cycle.
- Assert `rst`=0 mid-MEASURE (cycle 7) → immediate IDLE, outputs 0. `start` pulses during MEASURE are ignored (window length unchanged).
